// File: rtl/bcd_decimal_decoder.sv
// -----------------------------------------------------------------------------
// bcd_decimal_decoder
//
// Registered 8421-BCD to 1-of-10 decimal decoder with the '42-style pinout.
// A is the LSB and D is the MSB. The block samples the code on every rising
// clock edge. It drives one of ten select lines Y0..Y9 and flags codes 10..15
// as invalid. It is meant to sit between a BCD source, such as a counter or
// register, and display or select logic.
//
// Parameters
//   ACTIVE_LOW : 1 -> the selected Y is 0 and the others are 1 ('42 polarity)
//                0 -> the selected Y is 1 and the others are 0
//   ERR_CNT_W  : width of the invalid-code counter (only used when
//                FOURTO10_ERRCNT_EN is defined)
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   A,B,C,D  in   BCD code bits, with weights 1, 2, 4 and 8
//   Y0..Y9   out  registered decimal selects; polarity set by ACTIVE_LOW
//   invalid  out  registered; 1 when the last sampled code was 10..15
//   err_cnt  out  saturating count of invalid codes (FOURTO10_ERRCNT_EN only)
//
// Configuration macro: FOURTO10_ERRCNT_EN
//   When defined, the err_cnt port and its counter are present.
//   When undefined, both are absent and all other behaviour is identical.
//
// Timing: the outputs show the code sampled at the previous edge, so the
// latency is exactly one cycle. Reset forces every Y to its inactive level
// at once, without waiting for a clock edge. There is no handshake: the
// code is consumed every cycle.
// -----------------------------------------------------------------------------
module bcd_decimal_decoder #(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic Y0,
  output logic Y1,
  output logic Y2,
  output logic Y3,
  output logic Y4,
  output logic Y5,
  output logic Y6,
  output logic Y7,
  output logic Y8,
  output logic Y9,
`ifdef FOURTO10_ERRCNT_EN
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  output logic invalid
);

  logic [3:0] w_code;
  logic [9:0] w_onehot;
  logic       w_invalid;
  logic [9:0] w_y_next;

  logic [9:0] r_y;
  logic       r_invalid;

  assign w_code = {D, C, B, A};

  // One-hot decode of the valid codes. For codes 10..15 the vector stays
  // all-zero, so every output lands at its inactive level.
  always_comb begin
    w_onehot = 10'b0;
    case (w_code)
      4'd0: w_onehot = 10'b00_0000_0001;
      4'd1: w_onehot = 10'b00_0000_0010;
      4'd2: w_onehot = 10'b00_0000_0100;
      4'd3: w_onehot = 10'b00_0000_1000;
      4'd4: w_onehot = 10'b00_0001_0000;
      4'd5: w_onehot = 10'b00_0010_0000;
      4'd6: w_onehot = 10'b00_0100_0000;
      4'd7: w_onehot = 10'b00_1000_0000;
      4'd8: w_onehot = 10'b01_0000_0000;
      4'd9: w_onehot = 10'b10_0000_0000;
      default: w_onehot = 10'b0;
    endcase
  end

  assign w_invalid = (w_code > 4'd9);

  // Apply the output polarity before the register. The Y pins then come
  // straight from flops and cannot glitch.
  assign w_y_next = ACTIVE_LOW ? ~w_onehot : w_onehot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y       <= {10{ACTIVE_LOW}};
      r_invalid <= 1'b0;
    end else begin
      r_y       <= w_y_next;
      r_invalid <= w_invalid;
    end
  end

  assign Y0      = r_y[0];
  assign Y1      = r_y[1];
  assign Y2      = r_y[2];
  assign Y3      = r_y[3];
  assign Y4      = r_y[4];
  assign Y5      = r_y[5];
  assign Y6      = r_y[6];
  assign Y7      = r_y[7];
  assign Y8      = r_y[8];
  assign Y9      = r_y[9];
  assign invalid = r_invalid;

`ifdef FOURTO10_ERRCNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Saturating counter: it holds at all-ones rather than wrapping, so a long
  // burst of bad codes is never reported as a small count. Only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_invalid && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_bcd_decimal_decoder.sv
// -----------------------------------------------------------------------------
// tb_bcd_decimal_decoder
//
// The bench drives two decoder instances from the same BCD inputs:
//   u_dut_lo : ACTIVE_LOW = 1
//   u_dut_hi : ACTIVE_LOW = 0
// With FOURTO10_ERRCNT_EN defined, a third instance u_dut_sat uses
// ERR_CNT_W = 2 to exercise counter saturation.
//
// The driver sets the code on the falling edge. At the same moment it pushes
// the hand-written expected response into exp_q, packed as {code, invalid, y}.
// The monitor wakes 1 time unit after each rising edge, pops one entry and
// compares it with both instances.
// -----------------------------------------------------------------------------
module tb_bcd_decimal_decoder;

  logic clk;
  logic rst;
  logic A, B, C, D;
  logic [9:0] y_lo, y_hi;
  logic inv_lo, inv_hi;
`ifdef FOURTO10_ERRCNT_EN
  logic [7:0] err_cnt;
  logic [1:0] err_cnt_sat;
  logic [9:0] y_sat;
  logic       inv_sat;
`endif

  int total = 0;
  int bad   = 0;

  // {code[3:0], invalid, y[9:0]}. The y field uses ACTIVE_LOW=1 polarity.
  logic [14:0] exp_q[$];

  // Expected Y9..Y0 for the active-low part, written out by hand for each code.
  logic [9:0] exp_y_tab [16];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  bcd_decimal_decoder #(.ACTIVE_LOW(1'b1), .ERR_CNT_W(8)) u_dut_lo (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
    .Y0(y_lo[0]), .Y1(y_lo[1]), .Y2(y_lo[2]), .Y3(y_lo[3]), .Y4(y_lo[4]),
    .Y5(y_lo[5]), .Y6(y_lo[6]), .Y7(y_lo[7]), .Y8(y_lo[8]), .Y9(y_lo[9]),
`ifdef FOURTO10_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .invalid(inv_lo)
  );

  bcd_decimal_decoder #(.ACTIVE_LOW(1'b0), .ERR_CNT_W(8)) u_dut_hi (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
    .Y0(y_hi[0]), .Y1(y_hi[1]), .Y2(y_hi[2]), .Y3(y_hi[3]), .Y4(y_hi[4]),
    .Y5(y_hi[5]), .Y6(y_hi[6]), .Y7(y_hi[7]), .Y8(y_hi[8]), .Y9(y_hi[9]),
`ifdef FOURTO10_ERRCNT_EN
    .err_cnt(),
`endif
    .invalid(inv_hi)
  );

`ifdef FOURTO10_ERRCNT_EN
  bcd_decimal_decoder #(.ACTIVE_LOW(1'b1), .ERR_CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
    .Y0(y_sat[0]), .Y1(y_sat[1]), .Y2(y_sat[2]), .Y3(y_sat[3]), .Y4(y_sat[4]),
    .Y5(y_sat[5]), .Y6(y_sat[6]), .Y7(y_sat[7]), .Y8(y_sat[8]), .Y9(y_sat[9]),
    .err_cnt(err_cnt_sat),
    .invalid(inv_sat)
  );
`endif

  // ---------------- compare helpers ----------------
  task automatic check10(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Sets the code now and queues the response expected after the next edge.
  task automatic drive_now(input logic [3:0] code);
    {D, C, B, A} = code;
    exp_q.push_back({code, (code > 4'd9), exp_y_tab[code]});
  endtask

  task automatic apply(input logic [3:0] code);
    @(negedge clk);
    drive_now(code);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [14:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check10($sformatf("y_lo code=%0d", e[14:11]), y_lo, e[9:0]);
        check1($sformatf("inv_lo code=%0d", e[14:11]), inv_lo, e[10]);
        check10($sformatf("y_hi code=%0d", e[14:11]), y_hi, ~e[9:0]);
        check1($sformatf("inv_hi code=%0d", e[14:11]), inv_hi, e[10]);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int wait_cycles;

    exp_y_tab[0]  = 10'b11_1111_1110;
    exp_y_tab[1]  = 10'b11_1111_1101;
    exp_y_tab[2]  = 10'b11_1111_1011;
    exp_y_tab[3]  = 10'b11_1111_0111;
    exp_y_tab[4]  = 10'b11_1110_1111;
    exp_y_tab[5]  = 10'b11_1101_1111;
    exp_y_tab[6]  = 10'b11_1011_1111;
    exp_y_tab[7]  = 10'b11_0111_1111;
    exp_y_tab[8]  = 10'b10_1111_1111;
    exp_y_tab[9]  = 10'b01_1111_1111;
    for (int i = 10; i < 16; i++) exp_y_tab[i] = 10'b11_1111_1111;

    // Hold reset while a valid code is present: the outputs must stay inactive.
    rst = 1'b1;
    {D, C, B, A} = 4'd7;
    #2;
    check10("reset y_lo", y_lo, 10'b11_1111_1111);
    check10("reset y_hi", y_hi, 10'b00_0000_0000);
    check1("reset inv_lo", inv_lo, 1'b0);
`ifdef FOURTO10_ERRCNT_EN
    check10("reset err_cnt", {2'b00, err_cnt}, 10'd0);
`endif
    @(posedge clk);
    #1;
    check10("reset held y_lo", y_lo, 10'b11_1111_1111);
    check1("reset held inv_hi", inv_hi, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Sweep the valid codes 0..9.
    for (int n = 0; n < 10; n++) apply(4'(n));

    // Code 10 (B and D set), then code 8 (D only).
    apply(4'd10);
    apply(4'd8);

    // Send the invalid codes back-to-back.
    for (int n = 10; n < 16; n++) apply(4'(n));
`ifdef FOURTO10_ERRCNT_EN
    @(negedge clk);
    check10("err_cnt after 7 invalid", {2'b00, err_cnt}, 10'd7);
    check10("err_cnt_sat saturated", {8'd0, err_cnt_sat}, 10'd3);
`endif

    // Assert reset asynchronously while Y3 is active.
    apply(4'd3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check10("async rst y_lo", y_lo, 10'b11_1111_1111);
    check10("async rst y_hi", y_hi, 10'b00_0000_0000);
`ifdef FOURTO10_ERRCNT_EN
    check10("async rst err_cnt", {2'b00, err_cnt}, 10'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    drive_now(4'd0);

    // Codes 5 and 12 again, for the polarity check on the active-high part.
    apply(4'd5);
    apply(4'd12);
    apply(4'd9);

    // Wait for the scoreboard to drain, with a fixed cycle limit.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
